// File: rtl/dsp_post_accumulator_if.sv
// Operand, control and result bundle for the DSP post-adder/accumulator.
// Latency: none, pure signal grouping.
// Backpressure: none; the stage accepts operands every cycle, gated only by CEP/CECARRYIN.
interface dsp_post_accumulator_if #(
   parameter int MWIDTH = 36,
   parameter int WIDTH  = 48
);
   logic              CEP;
   logic              CECARRYIN;
   logic [4:0]        OPMODE;
   logic [MWIDTH-1:0] M;
   logic [WIDTH-1:0]  C;
   logic [WIDTH-1:0]  PCIN;
   logic [WIDTH-1:0]  DAB;
   logic              CARRYIN;
   logic [WIDTH-1:0]  P;
   logic [WIDTH-1:0]  PCOUT;
   logic              CARRYOUT;
   logic              CARRYOUTF;

   // Operand source side (upstream pipeline / test driver).
   modport master (
      output CEP, CECARRYIN, OPMODE, M, C, PCIN, DAB, CARRYIN,
      input  P, PCOUT, CARRYOUT, CARRYOUTF
   );

   // Accumulator side.
   modport slave (
      input  CEP, CECARRYIN, OPMODE, M, C, PCIN, DAB, CARRYIN,
      output P, PCOUT, CARRYOUT, CARRYOUTF
   );
endinterface

// File: rtl/dsp_post_accumulator.sv
// Post-adder/accumulator: P = Z +/- (X + CIN) at WIDTH bits, with P_reg feedback.
// Latency: 1 cycle to P/CARRYOUT when PREG/CARRYOUTREG=1, 0 cycles otherwise; CYI adds 1 on carry-in.
// Backpressure: none; CEP/CECARRYIN freeze state, otherwise a new result every cycle.
module dsp_post_accumulator #(
   parameter int PREG        = 1,
   parameter int CARRYINREG  = 1,
   parameter int CARRYOUTREG = 1,
   parameter int MWIDTH      = 36,
   parameter int WIDTH       = 48
) (
   input  logic                  CLK,
   input  logic                  RST,
   dsp_post_accumulator_if.slave bus
);

   logic [WIDTH-1:0] p_reg;
   logic             co_reg;
   logic             cyi;
   logic [WIDTH-1:0] x_mux;
   logic [WIDTH-1:0] z_mux;
   logic             cin;
   logic [WIDTH:0]   r;

   // X operand select; the P choice always reads the register, never the output port.
   always_comb begin
      x_mux = '0;
      case (bus.OPMODE[1:0])
         2'd0: x_mux = '0;
         2'd1: x_mux = {{(WIDTH-MWIDTH){1'b0}}, bus.M};
         2'd2: x_mux = p_reg;
         2'd3: x_mux = bus.DAB;
         default: x_mux = '0;
      endcase
   end

   // Z operand select; P feedback again comes from the register to avoid a loop.
   always_comb begin
      z_mux = '0;
      case (bus.OPMODE[3:2])
         2'd0: z_mux = '0;
         2'd1: z_mux = bus.PCIN;
         2'd2: z_mux = p_reg;
         2'd3: z_mux = bus.C;
         default: z_mux = '0;
      endcase
   end

   assign cin = (CARRYINREG != 0) ? cyi : bus.CARRYIN;

   // One extra bit carries the add carry or the subtract borrow (X+CIN > Z).
   always_comb begin
      r = '0;
      if (bus.OPMODE[4])
         r = {1'b0, z_mux} - ({1'b0, x_mux} + {{WIDTH{1'b0}}, cin});
      else
         r = {1'b0, z_mux} + {1'b0, x_mux} + {{WIDTH{1'b0}}, cin};
   end

   // Carry-in stage, aligned with an upstream registered multiplier.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         cyi <= 1'b0;
      else if (bus.CECARRYIN)
         cyi <= bus.CARRYIN;
   end

   // Result and carry registers; P_reg also feeds the accumulate path.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         p_reg  <= '0;
         co_reg <= 1'b0;
      end else if (bus.CEP) begin
         p_reg  <= r[WIDTH-1:0];
         co_reg <= r[WIDTH];
      end
   end

   assign bus.P         = (PREG != 0) ? p_reg : r[WIDTH-1:0];
   assign bus.PCOUT     = bus.P;
   assign bus.CARRYOUT  = (CARRYOUTREG != 0) ? co_reg : r[WIDTH];
   assign bus.CARRYOUTF = bus.CARRYOUT;

endmodule
